// File: rtl/song_display_if.sv
// song_display_if: note digits from the melody player and the multiplexed 7-segment drive.
interface song_display_if;
    logic [3:0] high;
    logic [3:0] med;
    logic [3:0] low;
    logic [6:0] seg;
    logic [2:0] dig;
    modport master (output high, med, low, input seg, dig);
    modport slave (input high, med, low, output seg, dig);
endinterface

// File: rtl/song_display.sv
// song_display: synchronises the note bus and scans it onto a three-digit 7-segment display.
// Define SONG_DISPLAY_BLANK_EN to darken digits whose value is 0.
module song_display #(
    parameter int SCAN_DIV = 6000
) (
    input  logic          clk_6MHz,
    input  logic          rst_n,
    song_display_if.slave nb
);
`ifdef SONG_DISPLAY_BLANK_EN
    localparam logic [6:0] zero_glyph = 7'b0000000;
`else
    localparam logic [6:0] zero_glyph = 7'b0111111;
`endif
    logic [11:0] s1, s2, s2_d, held, held_nx, shadow;
    logic [15:0] pcnt;
    logic [1:0]  idx, idx_nx;
    logic [3:0]  val;
    logic        tick, frame;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = zero_glyph;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    // idx is the slot lit by the coming tick; the tick that lights slot 0 opens a frame
    always_comb begin
        held_nx = (s2 == s2_d) ? s2 : held;
        tick    = pcnt == 16'(SCAN_DIV - 1);
        frame   = tick && idx == 2'd0;
        idx_nx  = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
        val     = idx == 2'd0 ? held_nx[3:0] :
                  idx == 2'd1 ? shadow[7:4]  :
                  idx == 2'd2 ? shadow[11:8] : shadow[3:0];
    end

    always_ff @(posedge clk_6MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            s2_d   <= '0;
            held   <= '0;
            shadow <= '0;
            pcnt   <= '0;
            idx    <= '0;
            nb.dig <= 3'b111;
            nb.seg <= '0;
        end else begin
            s1   <= {nb.high, nb.med, nb.low};
            s2   <= s1;
            s2_d <= s2;
            held <= held_nx;
            pcnt <= tick ? '0 : pcnt + 16'd1;
            if (frame)
                shadow <= held_nx;
            if (tick) begin
                idx    <= idx_nx;
                nb.dig <= ~(3'b001 << idx);
                nb.seg <= decode(val);
            end
        end
    end
endmodule

// File: tb/tb_song_display.sv
// tb_song_display: scoreboard bench; stimulus queues expected {dig,seg} frames, a monitor pops on each output change.
module tb_song_display;
    logic clk_6MHz = 1'b0;
    logic rst_n;
    song_display_if nb_if ();
    song_display #(.SCAN_DIV(4)) dut (.clk_6MHz(clk_6MHz), .rst_n(rst_n), .nb(nb_if));

    always #5 clk_6MHz = ~clk_6MHz;

    logic [9:0] q[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;

    function automatic logic [6:0] g(input int v);
        logic [6:0] t [10];
        t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
`ifdef SONG_DISPLAY_BLANK_EN
        if (v == 0) return 7'b0000000;
`endif
        return (v < 10) ? t[v] : 7'b1000000;
    endfunction

    task automatic push(input logic [2:0] d, input int v);
        q.push_back({d, g(v)});
    endtask

    task automatic push_frame(input logic [11:0] b);
        push(3'b110, int'(b[3:0]));
        push(3'b101, int'(b[7:4]));
        push(3'b011, int'(b[11:8]));
    endtask

    task automatic set_bus(input logic [11:0] b);
        {nb_if.high, nb_if.med, nb_if.low} = b;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_6MHz);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d entries left, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [9:0] last, cur, e;
        last = {3'b111, 7'b0};
        forever begin
            @(negedge clk_6MHz);
            cur = {nb_if.dig, nb_if.seg};
            if (mon_en && cur !== last) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scan unexpected dig=%b seg=%b", cur[9:7], cur[6:0]);
                end else begin
                    e = q.pop_front();
                    if (cur !== e)
                        begin
                            errors++;
                            $display("FAIL scan got dig=%b seg=%b want dig=%b seg=%b",
                                     cur[9:7], cur[6:0], e[9:7], e[6:0]);
                        end
                end
                last = cur;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_bus(12'h053);
        repeat (3) @(negedge clk_6MHz);
        check("reset_dig", 12'(nb_if.dig), 12'h7);
        check("reset_seg", 12'(nb_if.seg), 12'h0);
        push_frame(12'h053);
        push_frame(12'h053);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_6MHz);
            check("pre_tick_dig", 12'(nb_if.dig), 12'h7);
        end
        drain();
        for (int v = 0; v < 16; v++) begin
            set_bus(12'(v));
            push_frame(12'(v));
            drain();
        end
        set_bus(12'h003);
        push(3'b110, 3);
        drain();
        set_bus(12'h007);
        push(3'b101, 0);
        push(3'b011, 0);
        push_frame(12'h007);
        drain();
        set_bus(12'h010);
        push_frame(12'h010);
        drain();
        set_bus(12'h100);
        push_frame(12'h010);
        push_frame(12'h010);
        @(negedge clk_6MHz);
        #1 set_bus(12'h010);
        drain();
        check("glitch_held", dut.held, 12'h010);
        push(3'b110, 0);
        push(3'b101, 1);
        drain();
        check("idx_before_reset", 12'(dut.idx), 12'h2);
        q.push_back({3'b111, 7'b0});
        rst_n = 1'b0;
        #1;
        check("midscan_dig", 12'(nb_if.dig), 12'h7);
        check("midscan_seg", 12'(nb_if.seg), 12'h0);
        repeat (2) @(negedge clk_6MHz);
        push_frame(12'h010);
        #1 rst_n = 1'b1;
        drain();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
